// File: rtl/truth_scan_pkg.sv
// Shared types and sizing for the truth-table scanner.
// The scanner walks all eight {b,a,c} input vectors of a 3-input function.
package truth_scan_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } scan_state_t;

  localparam int unsigned N_VEC = 32'd8;  // number of input vectors
  localparam int unsigned IDX_W = 32'd3;  // vector index width
  localparam int unsigned SET_W = 32'd4;  // settle counter width (SETTLE <= 15)

endpackage

// File: rtl/truth_table_scanner_settle_counter.sv
// Settle counter: counts 0..i_settle-1 while enabled and flags the terminal
// count, which the scanner uses as its "vector has settled" strobe.
module scan_settle_counter
  import truth_scan_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [SET_W-1:0] i_settle,
  output logic             o_tc
);

  logic [SET_W-1:0] r_count;
  logic [SET_W-1:0] w_last;

  assign w_last = i_settle - {{(SET_W-1){1'b0}}, 1'b1};
  assign o_tc   = i_en & (r_count == w_last);

  // Count while enabled, wrap to zero on terminal count or clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= {SET_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {SET_W{1'b0}};
    end else if (o_tc) begin
      r_count <= {SET_W{1'b0}};
    end else if (i_en) begin
      r_count <= r_count + {{(SET_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives all eight {b,a,c} vectors into a 3-input
// combinational block, samples y after SETTLE cycles per vector and publishes
// the 8-bit truth table with a one-cycle done pulse.
// Optional compare against EXPECTED: define TRUTH_SCAN_COMPARE_EN.
//
// All outputs are registered from the controller state, so they trail the
// state by one cycle. The sample strobe is delayed by one cycle as well so
// that y is always sampled against the vector actually on the pins; the last
// sample therefore lands on the same edge that publishes the table.
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter int unsigned SETTLE   = 32'd1,
  parameter logic [7:0]  EXPECTED = 8'h18
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_y,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_table
`ifdef TRUTH_SCAN_COMPARE_EN
  ,
  output logic       o_mismatch
`endif
);

  localparam logic [SET_W-1:0] SETTLE_V = SET_W'(SETTLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 32'd1);

  scan_state_t      r_state;
  scan_state_t      w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [N_VEC-1:0] r_shadow;
  logic [N_VEC-1:0] w_shadow_next;
  logic             r_sample;
  logic [IDX_W-1:0] r_sample_idx;
  logic [IDX_W-1:0] r_stim;
  logic             r_busy;
  logic             r_done;
  logic [N_VEC-1:0] r_table;
  logic             w_tc;
  logic             w_in_drive;

  assign w_in_drive = (r_state == DRIVE);

  scan_settle_counter u_settle (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (~w_in_drive),
    .i_en     (w_in_drive),
    .i_settle (SETTLE_V),
    .o_tc     (w_tc)
  );

  // Next-state logic for the scan controller.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = DRIVE;
        end else begin
          w_next_state = IDLE;
        end
      end
      DRIVE: begin
        if (w_tc && (r_idx == LAST_IDX)) begin
          w_next_state = DONE;
        end else begin
          w_next_state = DRIVE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Vector index: steps on each settle terminal count, never wraps mid-scan.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx <= {IDX_W{1'b0}};
    end else if (!w_in_drive) begin
      r_idx <= {IDX_W{1'b0}};
    end else if (w_tc && (r_idx != LAST_IDX)) begin
      r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      r_idx <= r_idx;
    end
  end

  // Sample strobe delayed one cycle to line up with the registered stimulus.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sample     <= 1'b0;
      r_sample_idx <= {IDX_W{1'b0}};
    end else begin
      r_sample     <= w_in_drive & w_tc;
      r_sample_idx <= r_idx;
    end
  end

  // Shadow table with the pending sample merged in.
  always_comb begin
    w_shadow_next = r_shadow;
    if (r_sample) begin
      w_shadow_next[r_sample_idx] = i_y;
    end else begin
      w_shadow_next = r_shadow;
    end
  end

  // Shadow register collects samples during the scan.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow <= {N_VEC{1'b0}};
    end else begin
      r_shadow <= w_shadow_next;
    end
  end

  // Registered stimulus, busy, done and published table.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stim  <= {IDX_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_table <= {N_VEC{1'b0}};
    end else begin
      r_stim  <= w_in_drive ? r_idx : {IDX_W{1'b0}};
      r_busy  <= w_in_drive;
      r_done  <= (r_state == DONE);
      r_table <= (r_state == DONE) ? w_shadow_next : r_table;
    end
  end

  assign o_b     = r_stim[2];
  assign o_a     = r_stim[1];
  assign o_c     = r_stim[0];
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_table = r_table;

`ifdef TRUTH_SCAN_COMPARE_EN
  logic r_mismatch;

  // Compare flag, published together with the table and held until the next one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mismatch <= 1'b0;
    end else if (r_state == DONE) begin
      r_mismatch <= (w_shadow_next != EXPECTED);
    end else begin
      r_mismatch <= r_mismatch;
    end
  end

  assign o_mismatch = r_mismatch;
`else
  logic w_unused_expected;
  assign w_unused_expected = ^EXPECTED;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: two instances (SETTLE=1 with a
// combinational function, SETTLE=3 with a 2-cycle delayed function), checked
// cycle by cycle against a timing model derived from acceptance-relative
// cycle numbers. Compare port checked when TRUTH_SCAN_COMPARE_EN is defined.
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] st;
  logic [1:0] a, b, c, busy, done, y;
  logic [7:0] tab [2];
  logic [7:0] fn  [2];
  logic       d1, d2;
`ifdef TRUTH_SCAN_COMPARE_EN
  logic [1:0] mis;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_tab [2];
  logic       m_mis [2];

  typedef struct {
    int         sel;
    logic [7:0] fn;
    logic [7:0] exp_tab;
  } vec_t;
  vec_t vt [10];

  always #5 clk = ~clk;

  // Function under test for instance 0: pure lookup, no delay.
  assign y[0] = fn[0][{b[0], a[0], c[0]}];

  // Function under test for instance 1: lookup delayed by two cycles.
  always @(posedge clk) begin
    d1 <= fn[1][{b[1], a[1], c[1]}];
    d2 <= d1;
  end
  assign y[1] = d2;

  truth_table_scanner #(.SETTLE(1), .EXPECTED(8'h18)) dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_start(st[0]), .i_y(y[0]),
    .o_a(a[0]), .o_b(b[0]), .o_c(c[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_table(tab[0])
`ifdef TRUTH_SCAN_COMPARE_EN
    , .o_mismatch(mis[0])
`endif
  );

  truth_table_scanner #(.SETTLE(3), .EXPECTED(8'hC0)) dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_start(st[1]), .i_y(y[1]),
    .o_a(a[1]), .o_b(b[1]), .o_c(c[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_table(tab[1])
`ifdef TRUTH_SCAN_COMPARE_EN
    , .o_mismatch(mis[1])
`endif
  );

  function automatic logic [7:0] gold(input int sel);
    return (sel == 0) ? 8'h18 : 8'hC0;
  endfunction

  function automatic int settle_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input int sel, input string tag, input bit exp_busy,
                             input int exp_vec, input bit exp_done);
    chk({tag, "_busy"}, 32'(busy[sel]), 32'(exp_busy));
    chk({tag, "_vec"},  32'({b[sel], a[sel], c[sel]}), 32'(exp_vec));
    chk({tag, "_done"}, 32'(done[sel]), 32'(exp_done));
    chk({tag, "_table"}, 32'(tab[sel]), 32'(m_tab[sel]));
`ifdef TRUTH_SCAN_COMPARE_EN
    chk({tag, "_mismatch"}, 32'(mis[sel]), 32'(m_mis[sel]));
`endif
  endtask

  // Raise start so that the next rising edge is the acceptance edge E0.
  task automatic accept(input int sel, input bit hold);
    #1 st[sel] = 1'b1;
    @(posedge clk);
    if (!hold) begin
      #1 st[sel] = 1'b0;
    end
  endtask

  // Check cycles E0 .. E0+8S+1; returns just after edge E0+8S+2.
  task automatic check_scan(input int sel, input logic [7:0] exp_tab, input bit keep);
    int  s;
    bit  eb;
    int  ev;
    s = settle_of(sel);
    for (int k = 0; k <= 8 * s + 1; k++) begin
      @(negedge clk);
      eb = (k >= 1) && (k <= 8 * s);
      ev = eb ? (k - 1) / s : 0;
      if (k == 8 * s + 1) begin
        m_tab[sel] = exp_tab;
        m_mis[sel] = (exp_tab != gold(sel));
      end
      chk_outputs(sel, "scan", eb, ev, (k == 8 * s + 1));
      if ((k == 8 * s + 1) && !keep) begin
        st[sel] = 1'b0;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    logic [7:0] r;
    rst = 2'b11;
    st  = 2'b00;
    fn[0] = 8'h00;
    fn[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;
    for (int s = 0; s < 2; s++) begin
      m_tab[s] = 8'h00;
      m_mis[s] = 1'b0;
    end
    @(negedge clk);
    chk_outputs(0, "reset0", 1'b0, 0, 1'b0);
    chk_outputs(1, "reset1", 1'b0, 0, 1'b0);
    @(posedge clk);

    // Directed and random functions; expected table from evaluating each vector.
    vt[0] = '{0, 8'h18, 8'h18};
    vt[1] = '{0, 8'h00, 8'h00};
    vt[2] = '{0, 8'hFF, 8'hFF};
    vt[3] = '{0, 8'hA5, 8'hA5};
    vt[4] = '{1, 8'hC0, 8'hC0};
    vt[5] = '{1, 8'h3C, 8'h3C};
    for (int i = 6; i < 10; i++) begin
      r = 8'($urandom_range(0, 255));
      vt[i].sel = i % 2;
      vt[i].fn  = r;
      for (int j = 0; j < 8; j++) begin
        vt[i].exp_tab[j] = ((r >> j) & 8'h01) != 8'h00;
      end
    end
    for (int i = 0; i < 10; i++) begin
      fn[vt[i].sel] = vt[i].fn;
      accept(vt[i].sel, 1'b0);
      check_scan(vt[i].sel, vt[i].exp_tab, 1'b0);
    end

    // Prior scan leaves 8'h18, then reset at E0+4 of the next scan.
    fn[0] = 8'h18;
    accept(0, 1'b0);
    check_scan(0, 8'h18, 1'b0);
    fn[0] = 8'hE7;
    accept(0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_outputs(0, "prereset", (k >= 1), (k >= 1) ? k - 1 : 0, 1'b0);
      if (k == 3) begin
        rst[0] = 1'b1;
      end
      @(posedge clk);
    end
    #1 rst[0] = 1'b0;
    m_tab[0] = 8'h00;
    m_mis[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_outputs(0, "midreset", 1'b0, 0, 1'b0);
      @(posedge clk);
    end

    // Start held high: one scan every 10 cycles, no extra scans.
    for (int i = 0; i < 3; i++) begin
      fn[0] = 8'($urandom_range(0, 255));
      if (i == 0) begin
        accept(0, 1'b1);
      end
      check_scan(0, fn[0], (i != 2));
    end
    @(negedge clk);
    chk_outputs(0, "afterhold", 1'b0, 0, 1'b0);
    @(posedge clk);

    // Reset and start together: reset wins, block stays idle.
    #1 rst[0] = 1'b1;
    st[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    st[0] = 1'b0;
    m_tab[0] = 8'h00;
    m_mis[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_outputs(0, "rststart", 1'b0, 0, 1'b0);
      @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus-and-capture stage placed directly upstream of the team's 3-input combinational function blocks (inputs `a`, `b`, `c`, output `y`). On a start request it drives all eight input vectors in `{b,a,c}` index order, waits a programmable settle time per vector, samples `y`, and assembles an 8-bit truth-table word indexed by `{b,a,c}`. The word is presented with a one-cycle `done` pulse. This makes the combinational stage checkable on silicon or on a bench without an external pattern source.

## Interface
- `SETTLE`, default 1: cycles each vector is held before `y` is sampled; legal range 1..15.
- `EXPECTED`, default 8'h18: golden truth table. Used only when the compare feature is compiled in.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  scan request; sampled only in IDLE.
- `y`  in  1  output of the function under test.
- `a`, `b`, `c`  out  1 each  registered stimulus to the function under test.
- `busy`  out  1  high from the cycle after acceptance through the last sample cycle.
- `done`  out  1  one-cycle pulse; `table` is valid from this cycle onward.
- `table`  out  8  captured truth table; bit *i* = `y` at `{b,a,c}` = *i*.
- `mismatch`  out  1  present only with `TRUTH_SCAN_COMPARE_EN`.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE:
  - `a`=`b`=`c`=0, `busy`=0, `done`=0.
  - `start`=1 at an edge moves to DRIVE, with `idx`=0 and settle count=0.
- DRIVE:
  - `{b,a,c}`=`idx` (3-bit).
  - Settle counter runs 0..SETTLE-1.
  - At the edge where the count equals SETTLE-1, `y` is written into shadow bit `idx`.
  - If `idx`=7, go to DONE; otherwise increment `idx` and clear the counter.
- DONE (exactly one cycle):
  - Shadow copies to `table`, `done`=1, `busy`=0, stimulus returns to 0.
  - Next state is always IDLE.
- `start` in DRIVE or DONE is ignored. It is not queued.
- `table` holds the previous result for the whole scan and updates only on DONE entry.
- `idx` never wraps mid-scan. The 8-entry limit ends the scan.
- Reset in any state, including mid-scan:
  - Next cycle is IDLE.
  - `table`, shadow, `idx` and counter are 0.
  - `done`, `busy` and `mismatch` are 0.
  - Stimulus is 0.
  - No partial result is published.
- Reset and `start` asserted together: reset wins, and the start request is lost.

## Timing
- Start accepted at edge E0. `busy`=1 from E0+1.
- Vector *i* is driven during cycles E0+1+i·SETTLE through E0+(i+1)·SETTLE.
- `done` pulses in the cycle beginning at edge E0+8·SETTLE+1.
  - SETTLE=1: `done` pulses 9 cycles after acceptance.
- Back-to-back scans: the earliest next acceptance is the edge ending the DONE cycle (`start` held high gives one scan every 8·SETTLE+2 cycles).
- `y` must be stable within SETTLE cycles of a stimulus change. The block does not check this.
- Reset values: every output is 0.

## Configuration
- Macro: `TRUTH_SCAN_COMPARE_EN`.
- Defined:
  - `mismatch` port exists.
  - It is registered and updated together with `table`, as (shadow != EXPECTED).
  - It holds until the next DONE or until reset.
- Undefined: no `mismatch` port, no compare logic, `EXPECTED` unused.

## Structure
- Package `truth_scan_pkg` contains:
  - state enum `scan_state_t` (IDLE, DRIVE, DONE);
  - `N_VEC`=8 and `IDX_W`=3;
  - `SET_W`=4 settle-counter width.
- One sub-module, `scan_settle_counter`: load/clear/terminal-count counter of width `SET_W`, with SETTLE as an input constant. It gives DRIVE its sample strobe.

## Test plan
- Reset, then `start` pulse, SETTLE=1, bench function = the team's 3-input reference function (expected 8'h18):
  - `done` at E0+9;
  - `table`=8'h18;
  - stimulus sequence {b,a,c} = 0..7, one per cycle;
  - `mismatch`=0 (macro on).
- Same scan with `EXPECTED`=8'hFF and macro on: `table`=8'h18, `mismatch`=1 in the `done` cycle, and `mismatch` holds after.
- SETTLE=3, bench function `y`=a&b delayed 2 cycles:
  - `table`=8'hC0;
  - `done` at E0+25;
  - each vector is held exactly 3 cycles.
- Assert `reset` at E0+4 after a completed prior scan left `table`=8'h18:
  - next cycle `table`=0, `busy`=0, stimulus 0;
  - no `done` pulse.
- Hold `start` high continuously, SETTLE=1:
  - `done` pulses every 10 cycles;
  - `start` in DRIVE/DONE creates no extra scans;
  - `table` is unchanged mid-scan.
- Pulse `start` together with `reset`: block stays in IDLE, and `busy` never rises.
